// File: rtl/pio_in_debounce_irq_if.sv
// pio_in_debounce_irq_if: word-addressed Avalon-MM slave bus of the input PIO
interface pio_in_debounce_irq_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pio_in_debounce_irq.sv
// pio_in_debounce_irq: debounced Avalon-MM input PIO with edge capture and level irq
module pio_in_debounce_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pio_in_debounce_irq_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s, commit, set, clr;
  logic [WIDTH-1:0] deb_q, deb_d, mask_q, mask_d, edgecap_q, edgecap_d;
  logic [1:0] mode_q, mode_d;
  logic [31:0] readdata_q, readdata_d, rd_mux;
  logic wr_mode, wr_mask, wr_ecap;
  assign s = sync_q[SYNC_STAGES-1];
  // any sample equal to deb restarts the count, so only a full stable run commits
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      commit[i] = s[i] != deb_q[i] && cnt_q[i] == LAST;
      cnt_d[i]  = (s[i] == deb_q[i] || commit[i]) ? '0 : cnt_q[i] + CW'(1);
    end
  end
  assign wr_mode   = bus.write && bus.address == 2'd1;
  assign wr_mask   = bus.write && bus.address == 2'd2;
  assign wr_ecap   = bus.write && bus.address == 2'd3;
  assign deb_d     = deb_q ^ commit;
  assign set       = commit & ((s & {WIDTH{mode_q[0]}}) | (~s & {WIDTH{mode_q[1]}}));
  assign clr       = wr_ecap ? bus.writedata[WIDTH-1:0] : '0;
  assign edgecap_d = (edgecap_q & ~clr) | set;
  assign mode_d    = wr_mode ? bus.writedata[1:0] : mode_q;
  assign mask_d    = wr_mask ? bus.writedata[WIDTH-1:0] : mask_q;
  assign rd_mux    = bus.address == 2'd0 ? 32'(deb_q) :
                     bus.address == 2'd1 ? 32'(mode_q) :
                     bus.address == 2'd2 ? 32'(mask_q) : 32'(edgecap_q);
  assign readdata_d   = bus.read ? rd_mux : readdata_q;
  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & mask_q);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= '0;
      mode_q     <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end
endmodule
